dmem_ctrl: RTL and testbench
============================

Name: dmem_ctrl

Overview:
- Parametrised data-memory controller. Replaces the fixed single-cycle 8-bit data memory beside the CPU core.
- The CPU issues load/store requests over a valid/ready handshake. Responses return after a configurable latency, and `busy` stalls the core meanwhile.
- Adds what the fixed memory lacks: generic width and depth, programmable read latency, out-of-range error reporting, and a saturating error counter.

Parameters:
- DATA_W, 8, data word width in bits.
- ADDR_W, 8, request address width in bits.
- DEPTH, 256, number of words implemented; legal addresses are 0..DEPTH-1, and DEPTH must be ≤ 2^ADDR_W.
- READ_LAT, 2, cycles from request acceptance to resp_valid; legal range 1..15.
- ERRCNT_W, 8, width of the error counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  CPU presents a request.
- req_ready  output  1  controller can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  ADDR_W  word address.
- req_wdata  input  DATA_W  store data.
- resp_valid  output  1  response available.
- resp_ready  input  1  CPU consumes the response.
- resp_rdata  output  DATA_W  load data; 0 for stores and errors.
- resp_err  output  1  request address ≥ DEPTH.
- busy  output  1  request in flight; CPU stall.
- err_count  output  ERRCNT_W  saturating count of erroneous requests.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, busy=0, err_count=0. Memory array contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - Acceptance = req_valid && req_ready at a rising edge.
  - On acceptance, latch addr/we/wdata and compute err = (req_addr ≥ DEPTH).
  - Store with !err: the array is written at the acceptance edge.
  - Load with !err: array data is read at the acceptance edge into a hold register.
  - Erroneous request: memory is untouched, hold data = 0, err_count increments (saturates at all-ones).
  - Next state is WAIT with cnt=READ_LAT-1 when READ_LAT>1, otherwise RESP.
- WAIT:
  - req_ready=0, busy=1.
  - cnt decrements each cycle; at cnt==0 go to RESP.
- RESP:
  - resp_valid=1, busy=1, req_ready=0.
  - resp_rdata and resp_err are held stable until resp_ready=1.
  - resp_ready=1 at an edge → IDLE.
  - resp_valid drops the cycle after the handshake.
- Latency and throughput:
  - Request accepted at edge k → resp_valid high from cycle k+READ_LAT.
  - With resp_ready tied high, at most one request per READ_LAT+1 cycles.
- Single outstanding request: req_* inputs are ignored outside IDLE. busy = (state≠IDLE).
- Read-after-write: a load accepted after a store's response returns the new data.
- Store responses: resp_rdata=0, with resp_err reflecting the range check.
- Reset mid-operation:
  - Returns to IDLE with no response.
  - A store already accepted stays committed.
  - err_count is cleared.
- Address width: req_addr is compared at full ADDR_W width. There is no wrap-around; out-of-range addresses never alias.
- resp_rdata width is exactly DATA_W; no sign extension.

Test Plan:
1. Reset, then store addr=0x10, data=0xA5, then load 0x10 (READ_LAT=2, resp_ready=1).
   - Store response 2 cycles after acceptance, with resp_err=0.
   - Load response exactly 2 cycles after acceptance, with resp_rdata=0xA5.
   - req_ready low throughout each transaction.
2. DEPTH=200: load addr=0xC8.
   - resp_err=1, resp_rdata=0, err_count=1.
   - Then store addr=0xFF, data=0x33, followed by a load of 0x37 (previously written 0x11): load returns 0x11 (no aliasing), err_count=2.
3. Hold resp_ready=0 for 5 cycles after a load of 0x10.
   - resp_valid and resp_rdata=0xA5 stable for all 5 cycles.
   - New req_valid is ignored (no write occurs).
   - resp_ready=1 → IDLE on the next edge.
4. READ_LAT=1 instance: load response 1 cycle after acceptance.
   - With resp_ready=1, back-to-back loads are accepted every 2 cycles.
5. Store 0x5A to 0x20, then assert reset during WAIT.
   - No resp_valid; outputs at reset values.
   - A later load of 0x20 returns 0x5A.
6. ERRCNT_W=2: issue 5 out-of-range loads; err_count reads 1,2,3,3,3.

Source files
------------

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: parametrised data-memory controller sitting beside the CPU core.
// The CPU can have one load/store request outstanding at a time.
// Its response appears READ_LAT cycles after the request cycle and waits
// until the CPU takes it. Requests to addresses >= DEPTH are answered with
// resp_err=1 and do not touch the array. Each such request also increments a
// saturating error counter.
//
// Handshake rules, which apply to both channels:
// - A transfer happens at a rising edge where valid && ready are both high.
// - The producer holds its payload stable while valid is high and ready is low.
// - The controller holds resp_rdata and resp_err steady for as long as
//   resp_valid is high without resp_ready.
//
// READ_LAT must lie in 1..15 and DEPTH must be no larger than 2**ADDR_W.
// The internal signal `state` names the FSM state for debug and checkers.
module dmem_ctrl #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 8,
    parameter int DEPTH    = 256,
    parameter int READ_LAT = 2,
    parameter int ERRCNT_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err,
    output logic                busy,
    output logic [ERRCNT_W-1:0] err_count
);

    localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so that DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]      LAT_M1    = 4'(READ_LAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    // cnt holds the number of WAIT cycles still to spend, counting the current one.
    logic [3:0]        cnt;
    logic              hold_err;
    logic [DATA_W-1:0] hold_rdata;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              accept;
    logic              addr_err;
    logic [IDX_W-1:0]  idx;

    // The address is compared at full width, so out-of-range addresses never alias.
    assign addr_err = ({1'b0, req_addr} >= DEPTH_EXT);
    assign idx      = req_addr[IDX_W-1:0];
    assign accept   = req_valid && req_ready && !reset;

    // Array write and load capture both happen at the acceptance edge.
    // Errors and stores capture zero.
    always_ff @(posedge clk) begin
        if (accept && !addr_err && req_we) begin
            mem[idx] <= req_wdata;
        end
        if (accept) begin
            hold_rdata <= (!addr_err && !req_we) ? mem[idx] : '0;
        end
    end

    // State register, latency counter, error flag and saturating error counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            hold_err  <= 1'b0;
            err_count <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                cnt      <= LAT_M1;
                hold_err <= addr_err;
                if (addr_err && (err_count != '1)) begin
                    err_count <= err_count + ERRCNT_W'(1);
                end
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    // Next-state logic: WAIT is skipped entirely when READ_LAT is 1.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (READ_LAT > 1) ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (cnt == 4'd1) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from state.
    // Response payload is forced to zero whenever no response is presented.
    always_comb begin
        req_ready  = (state == IDLE);
        busy       = (state != IDLE);
        resp_valid = (state == RESP);
        resp_rdata = resp_valid ? hold_rdata : '0;
        resp_err   = resp_valid && hold_err;
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Testbench for dmem_ctrl. Three instances cover different parameter sets:
//   d0: DEPTH=200, READ_LAT=2
//   d1: DEPTH=256, READ_LAT=1
//   d2: DEPTH=16,  READ_LAT=3, ERRCNT_W=2
// Expected values come from vector tables, hand-written sequences and a
// behavioural memory model.
module tb_dmem_ctrl;

    localparam int N = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic       reset;
    logic       req_valid  [N];
    logic       req_we     [N];
    logic       resp_ready [N];
    logic [7:0] req_addr   [N];
    logic [7:0] req_wdata  [N];
    logic       req_ready  [N];
    logic       resp_valid [N];
    logic       resp_err   [N];
    logic       busy       [N];
    logic [7:0] resp_rdata [N];
    logic [7:0] ec0;
    logic [7:0] ec1;
    logic [1:0] ec2;

    int checks   = 0;
    int failures = 0;

    dmem_ctrl #(.DEPTH(200), .READ_LAT(2)) u_d0 (
        .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]),
        .resp_err(resp_err[0]), .busy(busy[0]), .err_count(ec0)
    );

    dmem_ctrl #(.DEPTH(256), .READ_LAT(1)) u_d1 (
        .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]),
        .resp_err(resp_err[1]), .busy(busy[1]), .err_count(ec1)
    );

    dmem_ctrl #(.DEPTH(16), .READ_LAT(3), .ERRCNT_W(2)) u_d2 (
        .clk(clk), .reset(reset), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_we(req_we[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
        .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]), .resp_rdata(resp_rdata[2]),
        .resp_err(resp_err[2]), .busy(busy[2]), .err_count(ec2)
    );

    // Behavioural reference: per-instance word array and saturating error count.
    int         depth_m [N] = '{200, 256, 16};
    int         lat_m   [N] = '{2, 1, 3};
    int         ecmax_m [N] = '{255, 255, 3};
    logic [7:0] mdl_mem [N][256];
    bit         mdl_wr  [N][256];
    int         mdl_ec  [N];

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rd;
        logic       exp_err;
        int         exp_ec;
    } vec_t;

    vec_t tbl [6];

    function automatic logic [31:0] get_ec(input int d);
        case (d)
            0:       return {24'b0, ec0};
            1:       return {24'b0, ec1};
            default: return {30'b0, ec2};
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_req(input int d, input logic we, input int addr, input logic [7:0] wdata,
                             output logic [7:0] rd, output logic err, output int ec);
        if (addr >= depth_m[d]) begin
            err = 1'b1;
            rd  = 8'h00;
            if (mdl_ec[d] < ecmax_m[d]) mdl_ec[d]++;
        end else begin
            err = 1'b0;
            if (we) begin
                mdl_mem[d][addr] = wdata;
                mdl_wr[d][addr]  = 1'b1;
                rd = 8'h00;
            end else begin
                rd = mdl_mem[d][addr];
            end
        end
        ec = mdl_ec[d];
    endtask

    // Issues one request to instance d. The task starts and ends on a negedge
    // with the instance idle. When hold > 0, resp_ready is held low for that
    // many cycles while a conflicting store is offered. The task checks that
    // the response stays stable and that the store is refused.
    task automatic do_req(input int d, input logic we, input logic [7:0] addr,
                          input logic [7:0] wdata, input int hold,
                          output logic [7:0] rd, output logic err, output int lat,
                          output int start);
        bit stall_ok;
        bit stable_ok;
        check("ready_before_req", {31'b0, req_ready[d]}, 32'd1);
        start         = cyc;
        req_valid[d]  = 1'b1;
        req_we[d]     = we;
        req_addr[d]   = addr;
        req_wdata[d]  = wdata;
        resp_ready[d] = (hold == 0);
        @(negedge clk);
        req_valid[d] = 1'b0;
        lat          = 1;
        stall_ok     = 1'b1;
        while (resp_valid[d] !== 1'b1 && lat < 40) begin
            if (req_ready[d] !== 1'b0 || busy[d] !== 1'b1) stall_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (resp_valid[d] !== 1'b1) begin
            check("resp_timeout", 32'd0, 32'd1);
            rd  = 'x;
            err = 'x;
            resp_ready[d] = 1'b1;
        end else begin
            if (req_ready[d] !== 1'b0 || busy[d] !== 1'b1) stall_ok = 1'b0;
            check("stall_during_txn", {31'b0, stall_ok}, 32'd1);
            rd        = resp_rdata[d];
            err       = resp_err[d];
            stable_ok = 1'b1;
            for (int h = 0; h < hold; h++) begin
                req_valid[d] = 1'b1;
                req_we[d]    = 1'b1;
                req_addr[d]  = addr;
                req_wdata[d] = ~wdata;
                @(negedge clk);
                if (resp_valid[d] !== 1'b1 || resp_rdata[d] !== rd || resp_err[d] !== err ||
                    req_ready[d] !== 1'b0) stable_ok = 1'b0;
            end
            if (hold > 0) check("resp_hold_stable", {31'b0, stable_ok}, 32'd1);
            req_valid[d]  = 1'b0;
            resp_ready[d] = 1'b1;
            @(negedge clk);
            check("idle_after_resp",
                  {29'b0, resp_valid[d], req_ready[d], busy[d]}, 32'b010);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd, erd;
        logic       err, eerr;
        int         lat, st, st_prev, eec, addr, d, hold;
        logic       we;

        reset = 1'b1;
        for (int i = 0; i < N; i++) begin
            req_valid[i]  = 1'b0;
            req_we[i]     = 1'b0;
            req_addr[i]   = 8'h00;
            req_wdata[i]  = 8'h00;
            resp_ready[i] = 1'b0;
            mdl_ec[i]     = 0;
        end
        repeat (3) @(negedge clk);

        // Reset state of every instance.
        for (int i = 0; i < N; i++) begin
            check("rst_req_ready",  {31'b0, req_ready[i]}, 32'd1);
            check("rst_resp_valid", {31'b0, resp_valid[i]}, 32'd0);
            check("rst_busy",       {31'b0, busy[i]}, 32'd0);
            check("rst_rdata",      {24'b0, resp_rdata[i]}, 32'd0);
            check("rst_err",        {31'b0, resp_err[i]}, 32'd0);
            check("rst_err_count",  get_ec(i), 32'd0);
        end
        reset = 1'b0;
        @(negedge clk);

        // Store/load round trip, out-of-range handling and no aliasing on d0 (DEPTH=200).
        tbl[0] = '{1'b1, 8'h10, 8'hA5, 8'h00, 1'b0, 0};
        tbl[1] = '{1'b0, 8'h10, 8'h00, 8'hA5, 1'b0, 0};
        tbl[2] = '{1'b1, 8'h37, 8'h11, 8'h00, 1'b0, 0};
        tbl[3] = '{1'b0, 8'hC8, 8'h00, 8'h00, 1'b1, 1};
        tbl[4] = '{1'b1, 8'hFF, 8'h33, 8'h00, 1'b1, 2};
        tbl[5] = '{1'b0, 8'h37, 8'h00, 8'h11, 1'b0, 2};
        for (int i = 0; i < 6; i++) begin
            do_req(0, tbl[i].we, tbl[i].addr, tbl[i].wdata, 0, rd, err, lat, st);
            model_req(0, tbl[i].we, int'(tbl[i].addr), tbl[i].wdata, erd, eerr, eec);
            check("tbl_rdata", {24'b0, rd}, {24'b0, tbl[i].exp_rd});
            check("tbl_err",   {31'b0, err}, {31'b0, tbl[i].exp_err});
            check("tbl_lat",   lat, 32'd2);
            check("tbl_err_count", get_ec(0), tbl[i].exp_ec);
        end

        // Back-pressure on the response for 5 cycles, with a store offered meanwhile.
        do_req(0, 1'b0, 8'h10, 8'hEE, 5, rd, err, lat, st);
        check("hold_rdata", {24'b0, rd}, 32'hA5);
        do_req(0, 1'b0, 8'h10, 8'h00, 0, rd, err, lat, st);
        check("no_write_while_busy", {24'b0, rd}, 32'hA5);

        // READ_LAT=1: one-cycle latency and one accepted load every 2 cycles.
        do_req(1, 1'b1, 8'h40, 8'h77, 0, rd, err, lat, st);
        model_req(1, 1'b1, 8'h40, 8'h77, erd, eerr, eec);
        st_prev = st;
        for (int i = 0; i < 3; i++) begin
            do_req(1, 1'b0, 8'h40, 8'h00, 0, rd, err, lat, st);
            check("lat1_rdata", {24'b0, rd}, 32'h77);
            check("lat1_latency", lat, 32'd1);
            check("lat1_spacing", st - st_prev, 32'd2);
            st_prev = st;
        end

        // Reset while a store sits in WAIT: the store stays committed and no response appears.
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b1;
        req_addr[0]  = 8'h20;
        req_wdata[0] = 8'h5A;
        @(negedge clk);
        req_valid[0] = 1'b0;
        check("wait_busy", {30'b0, busy[0], resp_valid[0]}, 32'b10);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_outputs",
              {20'b0, resp_rdata[0], resp_valid[0], resp_err[0], busy[0], req_ready[0]},
              {20'b0, 8'h00, 4'b0001});
        check("midrst_err_count", get_ec(0), 32'd0);
        reset = 1'b0;
        mdl_mem[0][8'h20] = 8'h5A;
        mdl_wr[0][8'h20]  = 1'b1;
        for (int i = 0; i < N; i++) mdl_ec[i] = 0;
        @(negedge clk);
        do_req(0, 1'b0, 8'h20, 8'h00, 0, rd, err, lat, st);
        check("post_reset_load", {24'b0, rd}, 32'h5A);

        // 2-bit error counter saturates at 3.
        for (int i = 0; i < 5; i++) begin
            do_req(2, 1'b0, 8'h80, 8'h00, 0, rd, err, lat, st);
            model_req(2, 1'b0, 8'h80, 8'h00, erd, eerr, eec);
            check("sat_err", {31'b0, err}, 32'd1);
            check("sat_lat", lat, 32'd3);
            check("sat_count", get_ec(2), (i < 3) ? i + 1 : 3);
        end

        // Random traffic against the model on all three instances.
        for (int i = 0; i < 90; i++) begin
            d     = $urandom_range(0, N - 1);
            we    = 1'($urandom_range(0, 1));
            addr  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255)
                                                : $urandom_range(0, depth_m[d] - 1);
            if (!we && addr < depth_m[d] && !mdl_wr[d][addr]) we = 1'b1;
            hold  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            model_req(d, we, addr, 8'($urandom), erd, eerr, eec);
            // Stores send the word the model recorded; loads send don't-care data.
            do_req(d, we, 8'(addr), we ? mdl_mem[d][addr] : 8'($urandom), hold, rd, err, lat, st);
            check("rnd_rdata", {24'b0, rd}, {24'b0, erd});
            check("rnd_err", {31'b0, err}, {31'b0, eerr});
            check("rnd_lat", lat, lat_m[d]);
            check("rnd_err_count", get_ec(d), eec);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
